// File: rtl/pa_core_xreg_wbctrl.sv
// Write-back controller: round-robin arbitration of N requesters onto the single
// register-file write port, plus a busy scoreboard that stalls issue on RAW/WAW.
module pa_core_xreg_wbctrl #(
  parameter int REQ_NUM = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        iss_vld_i,
  input  logic                        iss_rd_vld_i,
  input  logic [ADDR_W-1:0]           iss_rd_i,
  input  logic [ADDR_W-1:0]           iss_rs1_i,
  input  logic [ADDR_W-1:0]           iss_rs2_i,
  output logic                        iss_stall_o,
  input  logic [REQ_NUM-1:0]          req_vld_i,
  input  logic [REQ_NUM*ADDR_W-1:0]   req_addr_i,
  input  logic [REQ_NUM*DATA_W-1:0]   req_data_i,
  output logic [REQ_NUM-1:0]          req_rdy_o,
  output logic [ADDR_W-1:0]           reg_waddr_o,
  output logic                        reg_waddr_vld_o,
  output logic [DATA_W-1:0]           reg_wdata_o,
  output logic [31:0]                 busy_o
);

  localparam int IDX_W = (REQ_NUM > 2) ? 2 : 1;

  logic [IDX_W-1:0]  last_q, last_d;
  logic [31:0]       busy_q, busy_d;
  logic              wvld_q, wvld_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [REQ_NUM-1:0] gnt;
  logic               gnt_any;
  logic [IDX_W-1:0]   gnt_idx;
  logic [ADDR_W-1:0]  gnt_addr;
  logic [DATA_W-1:0]  gnt_data;
  logic               iss_fire;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= REQ_NUM) s = s - REQ_NUM;
    return s[IDX_W-1:0];
  endfunction

  // Search starts one past the last winner and wraps, so every requester is
  // reached within REQ_NUM grants.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    gnt     = '0;
    gnt_any = 1'b0;
    gnt_idx = last_q;
    for (int k = 1; k <= REQ_NUM; k++) begin
      if (!gnt_any && req_vld_i[rr_idx(last_q, k)]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_idx(last_q, k);
      end
    end
    if (gnt_any) gnt[gnt_idx] = 1'b1;
    gnt_addr = req_addr_i[gnt_idx*ADDR_W +: ADDR_W];
    gnt_data = req_data_i[gnt_idx*DATA_W +: DATA_W];
  end

  assign iss_stall_o = iss_vld_i & (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] |
                                    (iss_rd_vld_i & busy_q[iss_rd_i]));
  assign iss_fire    = iss_vld_i & iss_rd_vld_i & ~iss_stall_o & (iss_rd_i != '0);

  always_comb begin
    last_d  = gnt_any ? gnt_idx : last_q;
    wvld_d  = gnt_any & (gnt_addr != '0);
    waddr_d = wvld_d ? gnt_addr : waddr_q;
    wdata_d = wvld_d ? gnt_data : wdata_q;
    busy_d  = busy_q;
    if (iss_fire) busy_d[iss_rd_i] = 1'b1;
    // Clear at grant: the register file writes through to same-cycle reads, so the
    // consumer may issue while the registered write is on the port. Clear wins a tie.
    if (gnt_any)  busy_d[gnt_addr] = 1'b0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only.
      last_q  <= IDX_W'(REQ_NUM - 1);
      busy_q  <= '0;
      wvld_q  <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      last_q  <= last_d;
      busy_q  <= busy_d;
      wvld_q  <= wvld_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign req_rdy_o       = gnt;
  assign reg_waddr_vld_o = wvld_q;
  assign reg_waddr_o     = waddr_q;
  assign reg_wdata_o     = wdata_q;
  assign busy_o          = busy_q;

endmodule
